uart_tx_arbiter: RTL and testbench

- Shares one UART transmitter among N byte-stream requesters, e.g. cipher output, status/debug and loopback.
- Arbitrates round-robin at packet granularity: the grant is held until the requester's byte flagged last has been fully transmitted.
- Sequences the transmitter's start/busy handshake and presents each requester with a valid/ready interface.
- Sits between the datapath producers and the UART TX serializer.

---
 rtl/uart_pkg.sv | 23 ++
 rtl/rr_pick.sv | 36 +++
 rtl/uart_tx_arbiter.sv | 149 ++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: arbiter FSM states, header tag and frame timing
// constants common to the TX arbiter and the serializer.
package uart_pkg;

   typedef enum logic [2:0] {
      ST_ARB     = 3'd0,
      ST_HDR     = 3'd1,
      ST_LOAD    = 3'd2,
      ST_START   = 3'd3,
      ST_WAIT_HI = 3'd4,
      ST_WAIT_LO = 3'd5
   } state_t;

   localparam logic [3:0] HDR_TAG        = 4'hA;
   localparam int         CYCLES_PER_BIT = 16;
   // start + 8 data + odd parity + stop
   localparam int         FRAME_BITS     = 11;

   function automatic logic [7:0] hdr_byte(input logic [3:0] id);
      return {HDR_TAG, id};
   endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin priority encoder: first set request at or after
// ptr, wrapping modulo N_REQ. Returns one-hot pick, its index and any-hit.
module rr_pick
   import uart_pkg::*;
#(
   parameter int N_REQ = 3,
   parameter int ID_W  = 2
) (
   input  logic [N_REQ-1:0] req,
   input  logic [ID_W-1:0]  ptr,
   output logic [N_REQ-1:0] pick,
   output logic [ID_W-1:0]  idx,
   output logic             any
);

   logic found;
   int   j;

   always_comb begin
      pick  = '0;
      idx   = '0;
      found = 1'b0;
      j     = 0;
      for (int k = 0; k < N_REQ; k++) begin
         j = (int'(ptr) + k) % N_REQ;
         if (!found && req[j]) begin
            found   = 1'b1;
            pick[j] = 1'b1;
            idx     = ID_W'(j);
         end
      end
   end

   assign any = |req;

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-granular round-robin sharing of one UART transmitter among N_REQ
// byte streams. Define UART_TX_ARB_HDR_EN to prefix each packet with {A, id}.
module uart_tx_arbiter
   import uart_pkg::*;
#(
   parameter int N_REQ = 3,
   parameter int ID_W  = 2
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [N_REQ-1:0]     req_valid,
   input  logic [8*N_REQ-1:0]   req_data,
   input  logic [N_REQ-1:0]     req_last,
   output logic [N_REQ-1:0]     req_ready,
   output logic [N_REQ-1:0]     grant,
   output logic                 active,
   output logic                 tx_start,
   output logic [7:0]           tx_data,
   input  logic                 tx_busy
);

   state_t           state, state_n;
   logic [N_REQ-1:0] grant_n, pick;
   logic [ID_W-1:0]  gidx, gidx_n, rr_ptr, rr_n, pick_idx;
   logic             pick_any;
   logic             last_q, last_n;
   logic             tx_start_n;
   logic [7:0]       tx_data_n;
   logic             sel_valid, sel_last;
   logic [7:0]       sel_data;
`ifdef UART_TX_ARB_HDR_EN
   logic             hdr_q, hdr_n;
`endif

   rr_pick #(.N_REQ(N_REQ), .ID_W(ID_W)) u_pick (
      .req  (req_valid),
      .ptr  (rr_ptr),
      .pick (pick),
      .idx  (pick_idx),
      .any  (pick_any)
   );

   // Owner's byte, valid and last flag; grant is one-hot so OR-reduction muxes.
   always_comb begin
      sel_valid = |(req_valid & grant);
      sel_data  = '0;
      sel_last  = 1'b0;
      for (int i = 0; i < N_REQ; i++) begin
         if (grant[i]) begin
            sel_data = sel_data | req_data[8*i +: 8];
            sel_last = sel_last | req_last[i];
         end
      end
   end

   always_comb begin
      state_n   = state;
      grant_n   = grant;
      gidx_n    = gidx;
      rr_n      = rr_ptr;
      last_n    = last_q;
      tx_data_n = tx_data;
      req_ready = '0;
`ifdef UART_TX_ARB_HDR_EN
      hdr_n     = hdr_q;
`endif
      case (state)
         ST_ARB: begin
            if (pick_any) begin
               grant_n = pick;
               gidx_n  = pick_idx;
`ifdef UART_TX_ARB_HDR_EN
               state_n = ST_HDR;
`else
               state_n = ST_LOAD;
`endif
            end
         end
`ifdef UART_TX_ARB_HDR_EN
         ST_HDR: begin
            if (!tx_busy) begin
               tx_data_n = hdr_byte(4'(gidx));
               hdr_n     = 1'b1;
               state_n   = ST_START;
            end
         end
`endif
         ST_LOAD: begin
            // A stalled owner keeps the grant and blocks everyone else.
            if (sel_valid && !tx_busy) begin
               req_ready = grant;
               tx_data_n = sel_data;
               last_n    = sel_last;
               state_n   = ST_START;
            end
         end
         ST_START:   state_n = ST_WAIT_HI;
         ST_WAIT_HI: if (tx_busy) state_n = ST_WAIT_LO;
         ST_WAIT_LO: begin
            if (!tx_busy) begin
`ifdef UART_TX_ARB_HDR_EN
               if (hdr_q) begin
                  hdr_n   = 1'b0;
                  state_n = ST_LOAD;
               end else
`endif
               if (last_q) begin
                  grant_n = '0;
                  rr_n    = (gidx == ID_W'(N_REQ-1)) ? '0 : gidx + 1'b1;
                  state_n = ST_ARB;
               end else begin
                  state_n = ST_LOAD;
               end
            end
         end
         default: state_n = ST_ARB;
      endcase
      tx_start_n = (state_n == ST_START);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= ST_ARB;
         grant    <= '0;
         gidx     <= '0;
         rr_ptr   <= '0;
         last_q   <= 1'b0;
         tx_start <= 1'b0;
         tx_data  <= '0;
`ifdef UART_TX_ARB_HDR_EN
         hdr_q    <= 1'b0;
`endif
      end else begin
         state    <= state_n;
         grant    <= grant_n;
         gidx     <= gidx_n;
         rr_ptr   <= rr_n;
         last_q   <= last_n;
         tx_start <= tx_start_n;
         tx_data  <= tx_data_n;
`ifdef UART_TX_ARB_HDR_EN
         hdr_q    <= hdr_n;
`endif
      end
   end

   assign active = |grant;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: queued requesters, a 20-cycle busy
// transmitter model and hand-computed byte/grant/ready expectations.
module tb_uart_tx_arbiter;
   import uart_pkg::*;

   localparam int N        = 3;
   localparam int ID_W     = 2;
   localparam int BUSY_CYC = 20;
`ifdef UART_TX_ARB_HDR_EN
   localparam bit HDR_EN = 1'b1;
`else
   localparam bit HDR_EN = 1'b0;
`endif

   logic           clk = 1'b0;
   logic           rst_n;
   logic [N-1:0]   req_valid, req_last, req_ready, grant;
   logic [8*N-1:0] req_data;
   logic           active, tx_start;
   logic [7:0]     tx_data;
   logic           tx_busy = 1'b0;
   int             bcnt = 0;

   always #5 clk = ~clk;

   uart_tx_arbiter #(.N_REQ(N), .ID_W(ID_W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_data  (req_data),
      .req_last  (req_last),
      .req_ready (req_ready),
      .grant     (grant),
      .active    (active),
      .tx_start  (tx_start),
      .tx_data   (tx_data),
      .tx_busy   (tx_busy)
   );

   // Transmitter: busy rises the cycle after tx_start, stays up BUSY_CYC cycles.
   always @(posedge clk) begin
      if (!rst_n) begin
         tx_busy <= 1'b0;
         bcnt    <= 0;
      end else if (tx_start && !tx_busy) begin
         tx_busy <= 1'b1;
         bcnt    <= BUSY_CYC - 1;
      end else if (tx_busy) begin
         if (bcnt == 0) tx_busy <= 1'b0;
         else           bcnt    <= bcnt - 1;
      end
   end

   logic [8:0]   q [N][$];
   logic [N-1:0] en;
   logic [7:0]   txlog[$], hlog[$];
   logic [N-1:0] glog[$];
   int           rdy_cnt [N];
   int           nstart, viol, checks, errors;
   logic         hdr_pend;
   logic [N-1:0] prev_g, rdy_s;
   logic [7:0]   last_tx;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic drive();
      for (int i = 0; i < N; i++) begin
         req_valid[i] = en[i] && (q[i].size() > 0);
         if (q[i].size() > 0) begin
            req_data[8*i +: 8] = q[i][0][7:0];
            req_last[i]        = q[i][0][8];
         end else begin
            req_data[8*i +: 8] = 8'h00;
            req_last[i]        = 1'b0;
         end
      end
   endtask

   // One clock: observe at the falling edge, then update requesters after the rising edge.
   task automatic step();
      @(negedge clk);
      if (prev_g == '0 && grant != '0) hdr_pend = 1'b1;
      prev_g = grant;
      if (req_ready != '0 && (dut.state != ST_LOAD || (req_ready & ~grant) != '0 || !$onehot(req_ready)))
         viol++;
      if (tx_start && dut.state != ST_START) viol++;
      if (tx_busy && tx_data != last_tx) viol++;
      if (tx_start) begin
         nstart++;
         if (HDR_EN && hdr_pend) hlog.push_back(tx_data);
         else begin
            txlog.push_back(tx_data);
            glog.push_back(grant);
         end
         hdr_pend = 1'b0;
         last_tx  = tx_data;
      end
      rdy_s = req_ready;
      for (int i = 0; i < N; i++) rdy_cnt[i] += int'(rdy_s[i]);
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++)
         if (rdy_s[i] && q[i].size() > 0) void'(q[i].pop_front());
      drive();
   endtask

   function automatic bit all_empty();
      for (int i = 0; i < N; i++) if (q[i].size() > 0) return 1'b0;
      return 1'b1;
   endfunction

   function automatic logic [31:0] tlog(input int i);
      return (i < txlog.size()) ? 32'(txlog[i]) : 32'hFFFF;
   endfunction

   function automatic logic [31:0] gl(input int i);
      return (i < glog.size()) ? 32'(glog[i]) : 32'hFFFF;
   endfunction

   task automatic clear_logs();
      txlog.delete();
      hlog.delete();
      glog.delete();
      nstart = 0;
      for (int i = 0; i < N; i++) rdy_cnt[i] = 0;
   endtask

   task automatic run_idle(input string tag, input int budget);
      int n = 0;
      while (!(dut.state == ST_ARB && grant == '0 && !tx_busy && all_empty()) && n < budget) begin
         step();
         n++;
      end
      check_eq({tag, "_done"}, 32'(n < budget), 32'd1);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      checks = 0; errors = 0; viol = 0; nstart = 0;
      hdr_pend = 1'b0; prev_g = '0; last_tx = 8'h00; rdy_s = '0;
      en = '1;
      rst_n = 1'b0;
      clear_logs();
      q[1].push_back(9'h03C);
      q[1].push_back(9'h15A);
      drive();
      repeat (3) step();

      // Reset state, with a requester already valid.
      check_eq("rst_grant",  32'(grant),     32'd0);
      check_eq("rst_active", 32'(active),    32'd0);
      check_eq("rst_start",  32'(tx_start),  32'd0);
      check_eq("rst_data",   32'(tx_data),   32'd0);
      check_eq("rst_ready",  32'(req_ready), 32'd0);
      check_eq("rst_state",  32'(dut.state), 32'(ST_ARB));
      check_eq("rst_rrptr",  32'(dut.rr_ptr), 32'd0);

      // Two-byte packet from requester 1.
      rst_n = 1'b1;
`ifndef UART_TX_ARB_HDR_EN
      step();
      check_eq("t1_ready_lat", 32'(req_ready), 32'b010);
      step();
      check_eq("t1_start_lat", 32'(tx_start), 32'd1);
      check_eq("t1_data_lat",  32'(tx_data),  32'h3C);
`endif
      run_idle("t1", 400);
      check_eq("t1_nbytes", 32'(txlog.size()), 32'd2);
      check_eq("t1_byte0",  tlog(0), 32'h3C);
      check_eq("t1_byte1",  tlog(1), 32'h5A);
      check_eq("t1_rdy1",   32'(rdy_cnt[1]), 32'd2);
      check_eq("t1_rdyoth", 32'(rdy_cnt[0] + rdy_cnt[2]), 32'd0);
      check_eq("t1_grant",  32'(grant), 32'd0);
      check_eq("t1_rrptr",  32'(dut.rr_ptr), 32'd2);

      // All three valid at reset release.
      clear_logs();
      rst_n = 1'b0;
      step();
      q[0].push_back(9'h110);
      q[1].push_back(9'h120);
      q[2].push_back(9'h130);
      drive();
      step();
      check_eq("t2_rst_ready", 32'(req_ready), 32'd0);
      rst_n = 1'b1;
      run_idle("t2", 600);
      check_eq("t2_byte0", tlog(0), 32'h10);
      check_eq("t2_byte1", tlog(1), 32'h20);
      check_eq("t2_byte2", tlog(2), 32'h30);
      check_eq("t2_g0", gl(0), 32'b001);
      check_eq("t2_g1", gl(1), 32'b010);
      check_eq("t2_g2", gl(2), 32'b100);

      // Three-byte packet on 0 is not interrupted by pending requester 2.
      clear_logs();
      q[0].push_back(9'h001);
      q[0].push_back(9'h002);
      q[0].push_back(9'h103);
      q[2].push_back(9'h199);
      drive();
      run_idle("t3", 800);
      check_eq("t3_byte2", tlog(2), 32'h03);
      check_eq("t3_byte3", tlog(3), 32'h99);
      check_eq("t3_g2",    gl(2),   32'b001);
      check_eq("t3_g3",    gl(3),   32'b100);

      // Requester 0 re-requesting goes behind pending requester 1.
      clear_logs();
      q[0].push_back(9'h141);
      q[0].push_back(9'h142);
      q[1].push_back(9'h151);
      drive();
      run_idle("t3b", 600);
      check_eq("t3b_byte0", tlog(0), 32'h41);
      check_eq("t3b_byte1", tlog(1), 32'h51);
      check_eq("t3b_byte2", tlog(2), 32'h42);

      // Owner 1 stalls for 50 cycles mid-packet.
      clear_logs();
      q[1].push_back(9'h0C1);
      q[1].push_back(9'h1C2);
      q[2].push_back(9'h1D1);
      drive();
      n = 0;
      while (txlog.size() < 1 && n < 60) begin step(); n++; end
      check_eq("t4_first_started", 32'(n < 60), 32'd1);
      en[1] = 1'b0;
      drive();
      repeat (50) step();
      check_eq("t4_nostart", 32'(nstart), 32'd1);
      check_eq("t4_grant",   32'(grant), 32'b010);
      check_eq("t4_rdy2",    32'(rdy_cnt[2]), 32'd0);
      check_eq("t4_state",   32'(dut.state), 32'(ST_LOAD));
      en[1] = 1'b1;
      drive();
      run_idle("t4", 600);
      check_eq("t4_byte1", tlog(1), 32'hC2);
      check_eq("t4_byte2", tlog(2), 32'hD1);

      // Reset while waiting for busy to fall.
      clear_logs();
      q[0].push_back(9'h0E1);
      q[0].push_back(9'h1E2);
      drive();
      n = 0;
      while (dut.state != ST_WAIT_LO && n < 80) begin step(); n++; end
      check_eq("t5_reached_wlo", 32'(n < 80), 32'd1);
      rst_n = 1'b0;
      step();
      check_eq("t5_grant",  32'(grant),     32'd0);
      check_eq("t5_active", 32'(active),    32'd0);
      check_eq("t5_start",  32'(tx_start),  32'd0);
      check_eq("t5_ready",  32'(req_ready), 32'd0);
      check_eq("t5_state",  32'(dut.state), 32'(ST_ARB));
      for (int i = 0; i < N; i++) q[i].delete();
      drive();
      rst_n = 1'b1;
      repeat (3) step();

`ifdef UART_TX_ARB_HDR_EN
      // Header precedes the payload; only the payload is handshaken.
      clear_logs();
      q[2].push_back(9'h177);
      drive();
      run_idle("t6", 600);
      check_eq("t6_nhdr", 32'(hlog.size()), 32'd1);
      check_eq("t6_hdr",  (hlog.size() > 0) ? 32'(hlog[0]) : 32'hFFFF, 32'hA2);
      check_eq("t6_byte", tlog(0), 32'h77);
      check_eq("t6_rdy2", 32'(rdy_cnt[2]), 32'd1);
`endif

      check_eq("protocol_viol", 32'(viol), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
